alu_operand_stage: RTL and testbench

//  Operand-fetch stage directly upstream of the ALU. It accepts an operation request and reads
//  Rn and then Rm from the single-read-port register file over two cycles. It shifts the Rm value
//  and applies the A/B source selects. It then presents stable Ain/Bin/ALUop to the ALU under a

---
 rtl/alu_operand_stage_pkg.sv | 27 ++
 rtl/alu_operand_stage_if.sv | 35 +++
 rtl/alu_operand_stage_shifter.sv | 24 ++
 rtl/alu_operand_stage.sv | 108 ++++++++++
 tb/tb_alu_operand_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings for the ALU operand-fetch stage.
// The ALU decodes the same ALUop values.
package alu_operand_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int REGSEL_W = 3;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } aluop_e;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_READ_A  = 2'b01;
  localparam logic [1:0] ST_READ_B  = 2'b10;
  localparam logic [1:0] ST_PRESENT = 2'b11;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Request and operand handshake bundle.
// master issues requests and consumes operands.
interface alu_operand_stage_if #(
  parameter int DATA_W   = 16,
  parameter int REGSEL_W = 3
);
  logic                start;
  logic                in_ready;
  logic [REGSEL_W-1:0] rn;
  logic [REGSEL_W-1:0] rm;
  logic [1:0]          shift;
  logic [1:0]          op;
  logic                asel;
  logic                bsel;
  logic [DATA_W-1:0]   sximm5;
  logic [DATA_W-1:0]   Ain;
  logic [DATA_W-1:0]   Bin;
  logic [1:0]          ALUop;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output start, rn, rm, shift, op,
    output asel, bsel, sximm5, out_ready,
    input  in_ready, Ain, Bin, ALUop,
    input  out_valid
  );

  modport slave (
    input  start, rn, rm, shift, op,
    input  asel, bsel, sximm5, out_ready,
    output in_ready, Ain, Bin, ALUop,
    output out_valid
  );
endinterface

// File: rtl/alu_operand_stage_shifter.sv
// Single-bit shifter for the B operand.
// Purely combinational; no carry out.
module alu_operand_stage_shifter
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] y
);

  // select the shifted form of b
  always_comb begin
    y = b;
    unique case (shift)
      SH_LSL1: y = {b[DATA_W-2:0], 1'b0};
      SH_LSR1: y = {1'b0, b[DATA_W-1:1]};
      SH_ASR1: y = {b[DATA_W-1], b[DATA_W-1:1]};
      default: y = b;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch ahead of the ALU: reads Rn then Rm
// over the single register-file port, then presents.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REGSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  bus,
  output logic [REGSEL_W-1:0] readnum,
  input  logic [DATA_W-1:0]   rf_data
);

  logic [1:0]          state;
  logic [REGSEL_W-1:0] rn_q;
  logic [REGSEL_W-1:0] rm_q;
  logic [1:0]          shift_q;
  logic [1:0]          op_q;
  logic                asel_q;
  logic                bsel_q;
  logic [DATA_W-1:0]   sximm5_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_sh;
  logic [DATA_W-1:0]   ain_q;
  logic [DATA_W-1:0]   bin_q;
  logic [1:0]          aluop_q;
  logic                valid_q;

  alu_operand_stage_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .b     (rf_data),
    .shift (shift_q),
    .y     (b_sh)
  );

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.ALUop     = aluop_q;
  assign bus.out_valid = valid_q;

  // register-file index follows the read phase
  always_comb begin
    readnum = '0;
    unique case (state)
      ST_READ_A:  readnum = rn_q;
      ST_READ_B:  readnum = rm_q;
      ST_PRESENT: readnum = rm_q;
      default:    readnum = '0;
    endcase
  end

  // sequencer, request capture and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      op_q     <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      sximm5_q <= '0;
      a_q      <= '0;
      ain_q    <= '0;
      bin_q    <= '0;
      aluop_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            rn_q     <= bus.rn;
            rm_q     <= bus.rm;
            shift_q  <= bus.shift;
            op_q     <= bus.op;
            asel_q   <= bus.asel;
            bsel_q   <= bus.bsel;
            sximm5_q <= bus.sximm5;
            state    <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          a_q   <= rf_data;
          state <= ST_READ_B;
        end
        ST_READ_B: begin
          ain_q   <= asel_q ? '0 : a_q;
          bin_q   <= bsel_q ? sximm5_q : b_sh;
          aluop_q <= op_q;
          valid_q <= 1'b1;
          state   <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed requests,
// per-cycle model comparison and literal checks.
`timescale 1ns/1ps
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  readnum;
  logic [15:0] rf_data;
  logic [15:0] rf [8];

  int checks = 0;
  int errors = 0;

  alu_operand_stage_if #(.DATA_W(16), .REGSEL_W(3)) bus ();

  alu_operand_stage #(
    .DATA_W   (16),
    .REGSEL_W (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .readnum (readnum),
    .rf_data (rf_data)
  );

  assign rf_data = rf[readnum];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] shref(input logic [15:0] b,
                                        input logic [1:0] s);
    int unsigned v;
    v = b;
    case (s)
      2'd1: v = (v * 2) % 65536;
      2'd2: v = v / 2;
      2'd3: v = v / 2 + ((v >= 32768) ? 32768 : 0);
      default: ;
    endcase
    return v[15:0];
  endfunction

  // transaction-level model: age counts clocks since accept
  logic        m_busy, m_valid;
  int          m_age;
  logic [2:0]  m_rn, m_rm;
  logic [15:0] m_pa, m_pb, m_ain, m_bin;
  logic [1:0]  m_pop, m_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_valid <= 0; m_age <= 0;
      m_rn <= 0; m_rm <= 0; m_pa <= 0; m_pb <= 0;
      m_pop <= 0; m_ain <= 0; m_bin <= 0; m_op <= 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy <= 1;
        m_age  <= 1;
        m_rn   <= bus.rn;
        m_rm   <= bus.rm;
        m_pa   <= bus.asel ? 16'h0 : rf[bus.rn];
        m_pb   <= bus.bsel ? bus.sximm5
                           : shref(rf[bus.rm], bus.shift);
        m_pop  <= bus.op;
      end
    end else if (m_age < 3) begin
      m_age <= m_age + 1;
      if (m_age == 2) begin
        m_valid <= 1;
        m_ain   <= m_pa;
        m_bin   <= m_pb;
        m_op    <= m_pop;
      end
    end else if (bus.out_ready) begin
      m_valid <= 0;
      m_busy  <= 0;
      m_age   <= 0;
    end
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    logic [2:0] exp_rd;
    exp_rd = (m_age == 1) ? m_rn : (m_age >= 2) ? m_rm : 3'd0;
    chk("cyc_in_ready", bus.in_ready, !m_busy);
    chk("cyc_out_valid", bus.out_valid, m_valid);
    chk("cyc_readnum", readnum, exp_rd);
    chk("cyc_ain", bus.Ain, m_ain);
    chk("cyc_bin", bus.Bin, m_bin);
    chk("cyc_aluop", bus.ALUop, m_op);
  end

  // call at a negedge; returns at the negedge after accept
  task automatic send(input logic [2:0] rn_i, input logic [2:0] rm_i,
                      input logic [1:0] sh, input logic [1:0] op_i,
                      input logic as, input logic bs,
                      input logic [15:0] imm);
    bus.rn = rn_i; bus.rm = rm_i; bus.shift = sh; bus.op = op_i;
    bus.asel = as; bus.bsel = bs; bus.sximm5 = imm;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    bus.rn = 3'($urandom); bus.rm = 3'($urandom);
    bus.shift = 2'($urandom); bus.op = 2'($urandom);
    bus.asel = 1'($urandom); bus.bsel = 1'($urandom);
    bus.sximm5 = 16'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
  endtask

  logic [15:0] sh_exp [3];
  int n;
  time t1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sh_exp[0] = 16'h0006;
    sh_exp[1] = 16'h4001;
    sh_exp[2] = 16'hC001;
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
    rf[1] = 16'd3;
    rf[2] = 16'd2;
    bus.start = 0; bus.out_ready = 0;
    bus.rn = 0; bus.rm = 0; bus.shift = 0; bus.op = 0;
    bus.asel = 0; bus.bsel = 0; bus.sximm5 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ain", bus.Ain, 0);
    chk("rst_readnum", readnum, 0);
    rst_n = 1;
    @(negedge clk);

    // basic add: R1 + R2
    send(3'd1, 3'd2, 2'b00, 2'b00, 0, 0, 16'h0);
    chk("t2_readnum_a", readnum, 1);
    @(negedge clk);
    chk("t2_readnum_b", readnum, 2);
    wait_valid(n);
    chk("t2_latency", n, 1);
    chk("t2_ain", bus.Ain, 16'd3);
    chk("t2_bin", bus.Bin, 16'd2);
    chk("t2_aluop", bus.ALUop, 0);
    chk("t2_alu_sum", 32'((bus.Ain + bus.Bin) & 16'hFFFF), 5);
    handshake();

    // reset during READ_B
    send(3'd1, 3'd1, 2'b00, 2'b10, 0, 0, 16'h0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_ain", bus.Ain, 0);
    chk("t1_bin", bus.Bin, 0);
    chk("t1_aluop", bus.ALUop, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // shift table on 16'h8003
    rf[2] = 16'h8003;
    for (int i = 0; i < 3; i++) begin
      send(3'd1, 3'd2, 2'(i + 1), 2'b00, 0, 0, 16'h0);
      wait_valid(n);
      chk("t3_shift_bin", bus.Bin, sh_exp[i]);
      chk("t3_ain", bus.Ain, 16'd3);
      handshake();
    end

    // both sources overridden
    rf[5] = 16'h1234;
    rf[6] = 16'h5678;
    send(3'd5, 3'd6, 2'b01, 2'b01, 1, 1, 16'hFFFF);
    wait_valid(n);
    chk("t4_ain", bus.Ain, 16'h0000);
    chk("t4_bin", bus.Bin, 16'hFFFF);
    chk("t4_aluop", bus.ALUop, 2'b01);

    // stall 5 clocks with an ignored start
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.start = 1; bus.rn = 3'd1; bus.rm = 3'd1;
        bus.asel = 0; bus.bsel = 0; bus.op = 2'b11;
      end
      @(negedge clk);
      bus.start = 0;
      chk("t5_hold_valid", bus.out_valid, 1);
      chk("t5_hold_in_ready", bus.in_ready, 0);
      chk("t5_hold_bin", bus.Bin, 16'hFFFF);
      chk("t5_hold_aluop", bus.ALUop, 2'b01);
    end
    handshake();
    chk("t5_rel_valid", bus.out_valid, 0);
    chk("t5_rel_in_ready", bus.in_ready, 1);
    chk("t5_keep_bin", bus.Bin, 16'hFFFF);

    // back-to-back requests
    rf[3] = 16'h00F0;
    send(3'd3, 3'd3, 2'b10, 2'b10, 0, 0, 16'h0);
    wait_valid(n);
    t1 = $time;
    chk("t6_first_bin", bus.Bin, 16'h0078);
    handshake();
    send(3'd3, 3'd1, 2'b01, 2'b00, 0, 0, 16'h0);
    wait_valid(n);
    chk("t6_spacing", 32'(($time - t1) / 10), 4);
    chk("t6_ain", bus.Ain, 16'h00F0);
    chk("t6_bin", bus.Bin, 16'h0006);
    handshake();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
